// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency sprite ROM between two burst requesters.
// A granted burst always runs to completion, then one drain cycle while its last word returns.
module sprite_rom_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic              done0,
    output logic              done1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              owner_next;
    logic              last;
    logic              last_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_next;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_next;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic              rd_q;

    logic              pick;
    logic [LEN_W-1:0]  pick_len;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_next = state;
        owner_next = owner;
        last_next  = last;
        base_next  = base_q;
        len_next   = len_q;
        idx_next   = idx;
        pick       = 1'b0;
        pick_len   = '0;

        case (state)
            IDLE: begin
                // Under contention the requester that was not served last wins.
                if (req0 && req1) begin
                    pick = ~last;
                end else begin
                    pick = req1;
                end
                pick_len = pick ? len1 : len0;

                if (req0 || req1) begin
                    owner_next = pick;
                    last_next  = pick;
                    base_next  = pick ? base1 : base0;
                    len_next   = pick_len;
                    idx_next   = '0;
                    state_next = (pick_len == '0) ? DRAIN : BURST;
                end
            end

            BURST: begin
                idx_next = idx + LEN_ONE;
                if (idx == len_q - LEN_ONE) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            base_q <= '0;
            len_q  <= '0;
            idx    <= '0;
            rd_q   <= 1'b0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            last   <= last_next;
            base_q <= base_next;
            len_q  <= len_next;
            idx    <= idx_next;
            rd_q   <= (state == BURST);
        end
    end

    // Outputs decode registered state only; nothing here depends on req.
    assign rom_en   = (state == BURST);
    assign rom_addr = rom_en ? (base_q + ADDR_W'(idx)) : '0;

    assign gnt0   = (state != IDLE) && !owner;
    assign gnt1   = (state != IDLE) &&  owner;
    assign valid0 = rd_q && !owner;
    assign valid1 = rd_q &&  owner;
    assign done0  = (state == DRAIN) && !owner;
    assign done1  = (state == DRAIN) &&  owner;

    assign data0 = rom_data;
    assign data1 = rom_data;

endmodule
